// File: rtl/writeback_retire_queue.sv
// writeback_retire_queue: in-order writeback queue; loads wait for in-order data return,
// are aligned/extended at capture, and commit one entry per cycle to the register file.
module writeback_retire_queue #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_we,
    input  logic                     in_is_load,
    input  logic [REG_ADDR_W-1:0]    in_rd,
    input  logic [2:0]               in_funct3,
    input  logic [1:0]               in_addr_lsb,
    input  logic [XLEN-1:0]          in_result,
    input  logic                     ld_rsp_valid,
    input  logic [XLEN-1:0]          ld_rsp_data,
    input  logic                     flush,
    output logic                     rf_we,
    output logic [REG_ADDR_W-1:0]    rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic                     retire_valid,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic                  we_q   [DEPTH];
    logic                  ld_q   [DEPTH];
    logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
    logic [2:0]            f3_q   [DEPTH];
    logic [1:0]            lsb_q  [DEPTH];
    logic [XLEN-1:0]       data_q [DEPTH];
    logic                  ok_q   [DEPTH];

    logic [AW-1:0]         head_q, tail_q;
    logic [CW-1:0]         cnt_q, cnt_d, disc_q, disc_d;
    logic                  err_q, rf_we_q, retire_q;
    logic [REG_ADDR_W-1:0] rf_waddr_q;
    logic [XLEN-1:0]       rf_wdata_q;

    logic                  fnd;
    logic [AW-1:0]         fidx, idx;
    logic [CW-1:0]         outst;
    logic                  acc, pop, drop, fill, bad;
    logic [XLEN-1:0]       w, aligned;
    logic [2:0]            f3;

    // Oldest unfilled load and number of unfilled loads among occupied entries
    always_comb begin
        fnd   = 1'b0;
        fidx  = '0;
        idx   = head_q;
        outst = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if (CW'(i) < cnt_q && ld_q[idx] && !ok_q[idx]) begin
                outst = outst + CW'(1);
                fidx  = fnd ? fidx : idx;
                fnd   = 1'b1;
            end
        end
    end

    assign in_ready = !flush && ({1'b0, cnt_q} + {1'b0, disc_q}) < (CW+1)'(DEPTH);
    assign acc      = in_valid && in_ready;
    assign pop      = cnt_q != '0 && ok_q[head_q] && !flush;
    assign drop     = ld_rsp_valid && disc_q != '0;
    assign fill     = ld_rsp_valid && !drop && fnd;
    assign bad      = ld_rsp_valid && !drop && !fnd;

    assign f3      = f3_q[fidx];
    assign w       = ld_rsp_data >> {lsb_q[fidx], 3'b000};
    assign aligned = f3 == 3'b000 ? {{(XLEN-8){w[7]}}, w[7:0]} :
                     f3 == 3'b001 ? {{(XLEN-16){w[15]}}, w[15:0]} :
                     f3 == 3'b100 ? XLEN'(w[7:0]) :
                     f3 == 3'b101 ? XLEN'(w[15:0]) : w;

    // A response landing on the flush edge is applied before the remaining unfilled loads are counted
    assign disc_d = disc_q - CW'(drop) + (flush ? outst - CW'(fill) : '0);
    assign cnt_d  = flush ? '0 : cnt_q + CW'(acc) - CW'(pop);

    always_ff @(posedge clk) begin
        if (acc) begin
            we_q[tail_q]   <= in_we;
            ld_q[tail_q]   <= in_is_load;
            rd_q[tail_q]   <= in_rd;
            f3_q[tail_q]   <= in_funct3;
            lsb_q[tail_q]  <= in_addr_lsb;
            data_q[tail_q] <= in_result;
            ok_q[tail_q]   <= !in_is_load;
        end
        if (fill) begin
            data_q[fidx] <= aligned;
            ok_q[fidx]   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            disc_q     <= '0;
            err_q      <= 1'b0;
            rf_we_q    <= 1'b0;
            retire_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            head_q   <= flush ? '0 : head_q + AW'(pop);
            tail_q   <= flush ? '0 : tail_q + AW'(acc);
            cnt_q    <= cnt_d;
            disc_q   <= disc_d;
            err_q    <= err_q | bad;
            rf_we_q  <= pop && we_q[head_q] && rd_q[head_q] != '0;
            retire_q <= pop;
            if (pop) begin
                rf_waddr_q <= rd_q[head_q];
                rf_wdata_q <= data_q[head_q];
            end
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign retire_valid = retire_q;
    assign pending      = cnt_q;
    assign err          = err_q;
endmodule

// File: tb/tb_writeback_retire_queue.sv
// tb_writeback_retire_queue: directed table, corner sequences and random traffic
// checked against a queue-based reference model.
module tb_writeback_retire_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_we, in_is_load;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lsb;
    logic [31:0] in_result;
    logic        ld_rsp_valid;
    logic [31:0] ld_rsp_data;
    logic        flush;
    logic        rf_we, retire_valid, err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  pending;

    writeback_retire_queue #(.XLEN(32), .REG_ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
        .in_is_load(in_is_load), .in_rd(in_rd), .in_funct3(in_funct3), .in_addr_lsb(in_addr_lsb),
        .in_result(in_result), .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
        .flush(flush), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire_valid(retire_valid), .pending(pending), .err(err)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic        we, ld;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  lsb;
        logic [31:0] d;
        logic        ok;
    } ent_t;

    ent_t        mq[$];
    int          mdisc;
    logic        merr, mwe, mret;
    logic [4:0]  maddr;
    logic [31:0] mdata;

    typedef struct {
        logic        v, we, ld;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  lsb;
        logic [31:0] res;
        logic        rv;
        logic [31:0] rdata;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_ret;
        logic [2:0]  e_pend;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] raw, input logic [2:0] f3, input logic [1:0] lsb);
        logic [31:0] w;
        w = raw >> (8 * lsb);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic int unfilled();
        int n = 0;
        foreach (mq[i]) if (mq[i].ld && !mq[i].ok) n++;
        return n;
    endfunction

    function automatic logic model_ready();
        return !flush && (mq.size() + mdisc < DEPTH);
    endfunction

    task automatic model_reset();
        mq.delete();
        mdisc = 0; merr = 1'b0; mwe = 1'b0; mret = 1'b0; maddr = '0; mdata = '0;
    endtask

    // Applies one clock edge of the spec rules to the abstract queue
    task automatic model_step();
        logic rdy, pop, found;
        ent_t e;
        rdy = model_ready();
        pop = !flush && mq.size() > 0 && mq[0].ok;
        if (ld_rsp_valid) begin
            if (mdisc > 0) mdisc--;
            else begin
                found = 1'b0;
                foreach (mq[i]) if (!found && mq[i].ld && !mq[i].ok) begin
                    e = mq[i];
                    e.d = align(ld_rsp_data, e.f3, e.lsb);
                    e.ok = 1'b1;
                    mq[i] = e;
                    found = 1'b1;
                end
                if (!found) merr = 1'b1;
            end
        end
        mwe = 1'b0;
        mret = 1'b0;
        if (flush) begin
            mdisc += unfilled();
            mq.delete();
        end else begin
            if (pop) begin
                e = mq.pop_front();
                mret = 1'b1;
                mwe = e.we && e.rd != 0;
                maddr = e.rd;
                mdata = e.d;
            end
            if (in_valid && rdy) begin
                e.we = in_we; e.ld = in_is_load; e.rd = in_rd; e.f3 = in_funct3;
                e.lsb = in_addr_lsb; e.d = in_result; e.ok = !in_is_load;
                mq.push_back(e);
            end
        end
    endtask

    task automatic check_outs();
        chk("rf_we", rf_we, mwe);
        chk("retire_valid", retire_valid, mret);
        chk("rf_waddr", rf_waddr, maddr);
        chk("rf_wdata", rf_wdata, mdata);
        chk("pending", pending, mq.size());
        chk("err", err, merr);
    endtask

    task automatic cycle();
        #1;
        chk("in_ready", in_ready, model_ready());
        @(posedge clk);
        model_step();
        #1;
        check_outs();
    endtask

    task automatic drv(input logic v, input logic we, input logic ld, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [1:0] lsb, input logic [31:0] res,
                       input logic rv, input logic [31:0] rdata, input logic fl);
        in_valid = v; in_we = we; in_is_load = ld; in_rd = rd; in_funct3 = f3;
        in_addr_lsb = lsb; in_result = res; ld_rsp_valid = rv; ld_rsp_data = rdata; flush = fl;
        cycle();
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rsp(input logic [31:0] d);
        drv(0, 0, 0, 0, 0, 0, 0, 1, d, 0);
    endtask

    task automatic load(input logic [4:0] rd);
        drv(1, 1, 1, rd, 3'b010, 0, 0, 0, 0, 0);
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b1, 1'b0, 5'd1, 3'd0, 2'd0, 32'h11, 1'b0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 3'd1};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 5'd2, 3'd0, 2'd0, 32'h22, 1'b0, 32'h0,         1'b1, 5'd1, 32'h11,        1'b1, 3'd1};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 5'd3, 3'd0, 2'd0, 32'h33, 1'b0, 32'h0,         1'b1, 5'd2, 32'h22,        1'b1, 3'd1};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0,  1'b0, 32'h0,         1'b1, 5'd3, 32'h33,        1'b1, 3'd0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0,  1'b0, 32'h0,         1'b0, 5'd3, 32'h33,        1'b0, 3'd0};
        vt[5]  = '{1'b1, 1'b1, 1'b1, 5'd7, 3'd0, 2'd3, 32'h0,  1'b0, 32'h0,         1'b0, 5'd3, 32'h33,        1'b0, 3'd1};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0,  1'b1, 32'h80FF_FF00, 1'b0, 5'd3, 32'h33,        1'b0, 3'd1};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0,  1'b0, 32'h0,         1'b1, 5'd7, 32'hFFFF_FF80, 1'b1, 3'd0};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 5'd8, 3'd5, 2'd2, 32'h0,  1'b0, 32'h0,         1'b0, 5'd7, 32'hFFFF_FF80, 1'b0, 3'd1};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0,  1'b1, 32'h80FF_1234, 1'b0, 5'd7, 32'hFFFF_FF80, 1'b0, 3'd1};
        vt[10] = '{1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0,  1'b0, 32'h0,         1'b1, 5'd8, 32'h0000_80FF, 1'b1, 3'd0};
        vt[11] = '{1'b1, 1'b1, 1'b1, 5'd9, 3'd1, 2'd0, 32'h0,  1'b0, 32'h0,         1'b0, 5'd8, 32'h0000_80FF, 1'b0, 3'd1};
        vt[12] = '{1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0,  1'b1, 32'h0000_8001, 1'b0, 5'd8, 32'h0000_80FF, 1'b0, 3'd1};
        vt[13] = '{1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0,  1'b0, 32'h0,         1'b1, 5'd9, 32'hFFFF_8001, 1'b1, 3'd0};

        rst = 1'b0;
        in_valid = 0; in_we = 0; in_is_load = 0; in_rd = 0; in_funct3 = 0; in_addr_lsb = 0;
        in_result = 0; ld_rsp_valid = 0; ld_rsp_data = 0; flush = 0;
        model_reset();
        #12;
        chk("reset_rf_we", rf_we, 0);
        chk("reset_retire", retire_valid, 0);
        chk("reset_pending", pending, 0);
        chk("reset_err", err, 0);
        chk("reset_wdata", rf_wdata, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ALU back-to-back and load alignment vectors
        foreach (vt[i]) begin
            drv(vt[i].v, vt[i].we, vt[i].ld, vt[i].rd, vt[i].f3, vt[i].lsb, vt[i].res,
                vt[i].rv, vt[i].rdata, 1'b0);
            chk($sformatf("vec%0d_we", i), rf_we, vt[i].e_we);
            chk($sformatf("vec%0d_addr", i), rf_waddr, vt[i].e_addr);
            chk($sformatf("vec%0d_data", i), rf_wdata, vt[i].e_data);
            chk($sformatf("vec%0d_ret", i), retire_valid, vt[i].e_ret);
            chk($sformatf("vec%0d_pend", i), pending, vt[i].e_pend);
        end

        // Load blocks a younger ALU result until its delayed response
        load(5);
        drv(1, 1, 0, 6, 0, 0, 32'h66, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("t3_wait_we", rf_we, 0);
        end
        rsp(32'hAA);
        chk("t3_rsp_we", rf_we, 0);
        idle();
        chk("t3_ld_we", rf_we, 1);
        chk("t3_ld_addr", rf_waddr, 5);
        chk("t3_ld_data", rf_wdata, 32'hAA);
        idle();
        chk("t3_alu_addr", rf_waddr, 6);
        chk("t3_alu_data", rf_wdata, 32'h66);
        idle();

        // Full queue of loads
        for (int i = 0; i < DEPTH; i++) load(5'(10 + i));
        chk("t4_full_ready", in_ready, 0);
        chk("t4_full_pend", pending, DEPTH);
        rsp(32'h1);
        idle();
        chk("t4_commit_addr", rf_waddr, 10);
        chk("t4_ready_after", in_ready, 1);
        for (int i = 0; i < DEPTH - 1; i++) begin
            rsp(32'(i + 2));
            idle();
        end

        // Flush with outstanding loads; stale responses are dropped
        load(14);
        load(15);
        drv(1, 1, 0, 20, 0, 0, 32'h99, 0, 0, 1);
        chk("t5_flush_pend", pending, 0);
        chk("t5_flush_we", rf_we, 0);
        load(16);
        load(17);
        chk("t5_sum_full_ready", in_ready, 0);
        rsp(32'hDEAD);
        chk("t5_drop1_pend", pending, 2);
        rsp(32'hBEEF);
        rsp(32'h33);
        idle();
        chk("t5_fill_we", rf_we, 1);
        chk("t5_fill_addr", rf_waddr, 16);
        chk("t5_fill_data", rf_wdata, 32'h33);
        rsp(32'h44);
        idle();
        chk("t5_fill2_data", rf_wdata, 32'h44);
        idle();

        // rd=0 retire, stray response, asynchronous reset mid-stream
        drv(1, 1, 0, 0, 0, 0, 32'h55, 0, 0, 0);
        idle();
        chk("t6_rd0_ret", retire_valid, 1);
        chk("t6_rd0_we", rf_we, 0);
        rsp(32'h77);
        chk("t6_err", err, 1);
        idle();
        chk("t6_err_sticky", err, 1);
        load(21);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_err", err, 0);
        chk("t6_rst_pend", pending, 0);
        chk("t6_rst_waddr", rf_waddr, 0);
        chk("t6_rst_wdata", rf_wdata, 0);
        model_reset();
        #3 rst = 1'b1;
        idle();
        chk("t6_after_pend", pending, 0);
        chk("t6_after_ready", in_ready, 1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] f3s [6];
            logic rv;
            f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
            rv = ((unfilled() + mdisc) > 0 && $urandom_range(0, 2) == 0) || $urandom_range(0, 199) == 0;
            drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), f3s[$urandom_range(0, 5)], 2'($urandom_range(0, 3)),
                $urandom, rv, $urandom, $urandom_range(0, 24) == 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
